// File: rtl/window_feeder_pkg.sv
// Shared definitions for the window feeder slice.
//   pixel_t   : default-width pixel (BRAM data word)
//   state_t   : feeder FSM state encoding
//   BAND_ROWS : number of image rows streamed per band (window height)
package window_feeder_pkg;

    localparam int DEFAULT_BIT_DEPTH = 8;
    localparam int BAND_ROWS         = 3;

    typedef logic [DEFAULT_BIT_DEPTH-1:0] pixel_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_R0   = 3'd1,
        S_R1   = 3'd2,
        S_R2   = 3'd3,
        S_LAT  = 3'd4,
        S_PUSH = 3'd5
    } state_t;

endpackage

// File: rtl/window_addr_gen.sv
// Band/column counters and BRAM address generation for the window feeder.
//   clear    : restart the scan at row 0, column 0
//   advance  : one column was pushed; step column, or move to the next band
//   row_sel  : which band row (0..2) the current read targets
//   addr     : base + row_sel*IMG_W + col, base tracks top*IMG_W
//   top, col : current band top row and column
//   band_end : current column is the last one of the band
//   last     : current band is the final band of the image
module window_addr_gen
    import window_feeder_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic [1:0]        row_sel,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] top,
    output logic [ADDR_W-1:0] col,
    output logic              band_end,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STEP2 = ADDR_W'(2 * IMG_W);
    localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] TOP_LAST  = ADDR_W'(IMG_H - BAND_ROWS);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    // base always equals top*IMG_W; kept as a running sum so no multiplier
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] row_off;

    assign band_end = (col == COL_LAST);
    assign last     = (top == TOP_LAST);

    always_comb begin
        row_off = '0;
        case (row_sel)
            2'd1:    row_off = ROW_STEP;
            2'd2:    row_off = ROW_STEP2;
            default: row_off = '0;
        endcase
    end

    assign addr = base + row_off + col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top  <= '0;
            col  <= '0;
            base <= '0;
        end else if (clear) begin
            top  <= '0;
            col  <= '0;
            base <= '0;
        end else if (advance) begin
            if (!band_end) begin
                col <= col + ONE;
            end else if (!last) begin
                col  <= '0;
                top  <= top + ONE;
                base <= base + ROW_STEP;
            end
        end
    end

endmodule

// File: rtl/window_feeder.sv
// Reads an image from a 1-cycle-latency single-port BRAM and streams each
// 3-row band column by column into a 3x3 window register.
//   start/busy/done      : scan control (start pulse, busy level, done pulse)
//   bram_rd_en/addr/dout : BRAM read port, data valid one cycle after rd_en
//   win_ready/wr_en      : column handshake to the window register
//   in1..in3             : band rows top, top+1, top+2 of the pushed column
//   win_valid/row/col    : window holds a full 3x3 whose newest column is
//                          win_col and whose top row is win_row
//   state_dbg            : current FSM state
//
// Handshake: a column transfers on every cycle where wr_en and win_ready are
// both high. wr_en is raised only in PUSH and follows win_ready there; while
// win_ready is low the FSM waits in PUSH with in1..in3 held and no BRAM read.
module window_feeder
    import window_feeder_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int ADDR_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 bram_rd_en,
    output logic [ADDR_W-1:0]    bram_addr,
    input  logic [BIT_DEPTH-1:0] bram_dout,
    input  logic                 win_ready,
    output logic                 wr_en,
    output logic [BIT_DEPTH-1:0] in1,
    output logic [BIT_DEPTH-1:0] in2,
    output logic [BIT_DEPTH-1:0] in3,
    output logic                 win_valid,
    output logic [ADDR_W-1:0]    win_row,
    output logic [ADDR_W-1:0]    win_col,
    output state_t               state_dbg
);

    if (IMG_W < BAND_ROWS || IMG_H < BAND_ROWS) begin : g_bad_size
        $error("window_feeder: IMG_W and IMG_H must both be at least 3");
    end
    if ((IMG_W * IMG_H) > (1 << ADDR_W)) begin : g_bad_addr
        $error("window_feeder: ADDR_W too small for IMG_W*IMG_H");
    end

    localparam logic [ADDR_W-1:0] COL_FULL = ADDR_W'(BAND_ROWS - 1);

    state_t            state;
    logic [1:0]        row_sel;
    logic              clear;
    logic              advance;
    logic              band_end;
    logic              last;
    logic [ADDR_W-1:0] gen_addr;
    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] addr_hold;

    always_comb begin
        row_sel = 2'd0;
        case (state)
            S_R1:    row_sel = 2'd1;
            S_R2:    row_sel = 2'd2;
            default: row_sel = 2'd0;
        endcase
    end

    assign clear      = (state == S_IDLE) && start;
    assign wr_en      = (state == S_PUSH) && win_ready;
    assign advance    = wr_en;
    assign bram_rd_en = state inside {S_R0, S_R1, S_R2};
    // Address only moves while reading; otherwise the last read address stays
    assign bram_addr  = bram_rd_en ? gen_addr : addr_hold;
    assign state_dbg  = state;

    window_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .advance  (advance),
        .row_sel  (row_sel),
        .addr     (gen_addr),
        .top      (top),
        .col      (col),
        .band_end (band_end),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            in1       <= '0;
            in2       <= '0;
            in3       <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            addr_hold <= '0;
        end else begin
            done      <= 1'b0;
            win_valid <= 1'b0;
            if (bram_rd_en) begin
                addr_hold <= gen_addr;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_R0;
                        busy  <= 1'b1;
                    end
                end
                S_R0: state <= S_R1;
                // Each latch captures the read issued in the previous state
                S_R1: begin
                    in1   <= bram_dout;
                    state <= S_R2;
                end
                S_R2: begin
                    in2   <= bram_dout;
                    state <= S_LAT;
                end
                S_LAT: begin
                    in3   <= bram_dout;
                    state <= S_PUSH;
                end
                S_PUSH: begin
                    if (win_ready) begin
                        // Columns 0 and 1 of a band only prime the window
                        if (col >= COL_FULL) begin
                            win_valid <= 1'b1;
                            win_row   <= top;
                            win_col   <= col;
                        end
                        if (band_end && last) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_R0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_feeder.sv
// Directed bench for window_feeder: a 4x4 instance for timing, band change,
// backpressure, restart and reset-abort cases, and a default 8x8 instance
// fed with random win_ready and checked against a 3x3 window model.
module tb_window_feeder;
    import window_feeder_pkg::*;

    localparam int BD = 8;
    localparam int AW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- 4x4 instance ----------------
    logic          rst4, start4, win_ready4;
    logic          busy4, done4, rd_en4, wr_en4, win_valid4;
    logic [AW-1:0] addr4, win_row4, win_col4;
    logic [BD-1:0] dout4, p1_4, p2_4, p3_4;
    state_t        state4;

    window_feeder #(.BIT_DEPTH(BD), .IMG_W(4), .IMG_H(4), .ADDR_W(AW)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .busy(busy4), .done(done4),
        .bram_rd_en(rd_en4), .bram_addr(addr4), .bram_dout(dout4),
        .win_ready(win_ready4), .wr_en(wr_en4), .in1(p1_4), .in2(p2_4), .in3(p3_4),
        .win_valid(win_valid4), .win_row(win_row4), .win_col(win_col4),
        .state_dbg(state4)
    );

    // BRAM image: pixel value equals its address
    always @(posedge clk) if (rd_en4) dout4 <= 8'(addr4);

    int          push_cyc_q[$];
    logic [23:0] push_pix_q[$];
    int          val_cyc_q[$];
    logic [11:0] val_pos_q[$];
    int          done_cyc_q[$];
    int          r0_cyc = -1;
    int          first_rd_addr = -1;
    int          busy_at_done = -1;

    always @(negedge clk) begin
        if (wr_en4) begin
            push_cyc_q.push_back(cyc);
            push_pix_q.push_back({p1_4, p2_4, p3_4});
        end
        if (win_valid4) begin
            val_cyc_q.push_back(cyc);
            val_pos_q.push_back({win_row4, win_col4});
        end
        if (done4) begin
            done_cyc_q.push_back(cyc);
            busy_at_done = int'(busy4);
        end
        if (state4 == S_R0 && r0_cyc < 0) r0_cyc = cyc;
        if (rd_en4 && first_rd_addr < 0) first_rd_addr = int'(addr4);
    end

    task automatic clear_logs();
        push_cyc_q.delete();
        push_pix_q.delete();
        val_cyc_q.delete();
        val_pos_q.delete();
        done_cyc_q.delete();
        r0_cyc        = -1;
        first_rd_addr = -1;
        busy_at_done  = -1;
    endtask

    task automatic wait_done4(input string tag, input int bound, input bit restart);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            if (done4) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        if (seen && restart) begin
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            check("restart_at_done_busy", 32'(busy4), 1);
        end else begin
            @(negedge clk);
            #1;
        end
    endtask

    // Full 4x4 scan check; stall = cycles the first push was held off
    task automatic check_scan4(input string tag, input int stall);
        logic [23:0] exp_q[$];
        int a;
        for (int t = 0; t < 2; t++) begin
            for (int c = 0; c < 4; c++) begin
                a = t * 4 + c;
                exp_q.push_back({8'(a), 8'(a + 4), 8'(a + 8)});
            end
        end
        check({tag, "_npush"}, 32'(push_cyc_q.size()), 8);
        check({tag, "_first_rd_addr"}, 32'(first_rd_addr), 0);
        foreach (push_pix_q[k]) begin
            if (exp_q.size() > 0) begin
                check({tag, "_pix"}, 32'(push_pix_q[k]), 32'(exp_q.pop_front()));
                check({tag, "_push_cyc"}, 32'(push_cyc_q[k] - r0_cyc), 32'(4 + 5 * k + stall));
            end
        end
        check({tag, "_nvalid"}, 32'(val_cyc_q.size()), 4);
        if (val_cyc_q.size() == 4 && push_cyc_q.size() == 8) begin
            for (int j = 0; j < 4; j++) begin
                // valid windows come from pushes 2,3 (band 0) and 6,7 (band 1)
                check({tag, "_valid_pos"}, 32'(val_pos_q[j]), 32'({6'(j / 2), 6'(2 + j % 2)}));
                check({tag, "_valid_cyc"}, 32'(val_cyc_q[j]), 32'(push_cyc_q[2 + (j / 2) * 4 + j % 2] + 1));
            end
        end
        check({tag, "_ndone"}, 32'(done_cyc_q.size()), 1);
        if (done_cyc_q.size() == 1 && push_cyc_q.size() == 8) begin
            check({tag, "_done_cyc"}, 32'(done_cyc_q[0]), 32'(push_cyc_q[7] + 1));
            check({tag, "_busy_at_done"}, 32'(busy_at_done), 0);
        end
    endtask

    // ---------------- 8x8 instance ----------------
    logic          rst8, start8, win_ready8;
    logic          busy8, done8, rd_en8, wr_en8, win_valid8;
    logic [AW-1:0] addr8, win_row8, win_col8;
    logic [BD-1:0] dout8, p1_8, p2_8, p3_8;
    state_t        state8;
    bit            rand8 = 1'b0;
    bit            mon8  = 1'b0;

    window_feeder #(.BIT_DEPTH(BD), .IMG_W(8), .IMG_H(8), .ADDR_W(AW)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .busy(busy8), .done(done8),
        .bram_rd_en(rd_en8), .bram_addr(addr8), .bram_dout(dout8),
        .win_ready(win_ready8), .wr_en(wr_en8), .in1(p1_8), .in2(p2_8), .in3(p3_8),
        .win_valid(win_valid8), .win_row(win_row8), .win_col(win_col8),
        .state_dbg(state8)
    );

    always @(posedge clk) if (rd_en8) dout8 <= 8'(addr8);

    always @(posedge clk) begin
        if (rand8) begin
            #1;
            win_ready8 = 1'($urandom_range(0, 1));
        end
    end

    logic [23:0] exp8_q[$];
    pixel_t      win_m[3][3];
    bit          seen8[6][8];
    int          k8 = 0;
    int          nval8 = 0;
    bit          exp_v8 = 1'b0;
    int          exp_r8 = 0;
    int          exp_c8 = 0;

    always @(negedge clk) begin
        if (mon8) begin
            if (win_valid8 || exp_v8) begin
                check("v8_flag", 32'(win_valid8), 32'(exp_v8));
                if (win_valid8 && exp_v8) begin
                    check("v8_row", 32'(win_row8), 32'(exp_r8));
                    check("v8_col", 32'(win_col8), 32'(exp_c8));
                    check("v8_win_tl", 32'(win_m[0][0]), 32'(exp_r8 * 8 + exp_c8 - 2));
                    check("v8_win_br", 32'(win_m[2][2]), 32'((exp_r8 + 2) * 8 + exp_c8));
                    if (win_row8 < 6 && win_col8 < 8) begin
                        check("v8_unique", 32'(seen8[win_row8][win_col8]), 0);
                        seen8[win_row8][win_col8] = 1'b1;
                    end else begin
                        check("v8_range", 0, 1);
                    end
                    nval8++;
                end
            end
            exp_v8 = 1'b0;
            if (wr_en8) begin
                if (exp8_q.size() > 0) begin
                    check("p8_pix", 32'({p1_8, p2_8, p3_8}), 32'(exp8_q.pop_front()));
                end else begin
                    check("p8_extra_push", 1, 0);
                end
                for (int r = 0; r < 3; r++) begin
                    win_m[r][0] = win_m[r][1];
                    win_m[r][1] = win_m[r][2];
                end
                win_m[0][2] = p1_8;
                win_m[1][2] = p2_8;
                win_m[2][2] = p3_8;
                exp_v8 = ((k8 % 8) >= 2);
                exp_r8 = k8 / 8;
                exp_c8 = k8 % 8;
                k8++;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int  r2;
        int  covered;
        bit  seen;

        rst4 = 1'b1; rst8 = 1'b1;
        start4 = 1'b0; start8 = 1'b0;
        win_ready4 = 1'b1; win_ready8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy4), 0);
        check("rst_done", 32'(done4), 0);
        check("rst_rd_en", 32'(rd_en4), 0);
        check("rst_wr_en", 32'(wr_en4), 0);
        check("rst_win_valid", 32'(win_valid4), 0);
        check("rst_addr", 32'(addr4), 0);
        check("rst_pix", 32'({p1_4, p2_4, p3_4}), 0);
        check("rst_win_pos", 32'({win_row4, win_col4}), 0);
        check("rst_state", 32'(state4), 32'(S_IDLE));
        @(negedge clk);
        rst4 = 1'b0; rst8 = 1'b0;

        // Run A: plain scan with win_ready held high
        tick();
        clear_logs();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done4("runA", 200, 1'b0);
        check_scan4("runA", 0);

        // Run B: extra start pulses while busy; restart on the done cycle
        clear_logs();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (7) tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (12) tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done4("runB", 200, 1'b1);
        check_scan4("runB", 0);
        clear_logs();

        // Run C (started on runB's done cycle): 3-cycle stall at first push
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (state4 == S_PUSH) seen = 1'b1;
            else tick();
        end
        check("runC_reach_push", 32'(seen), 1);
        win_ready4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_wr_en", 32'(wr_en4), 0);
            check("stall_rd_en", 32'(rd_en4), 0);
            check("stall_pix", 32'({p1_4, p2_4, p3_4}), 32'({8'd0, 8'd4, 8'd8}));
            @(posedge clk);
            #1;
        end
        win_ready4 = 1'b1;
        @(negedge clk);
        check("stall_release_wr_en", 32'(wr_en4), 1);
        wait_done4("runC", 200, 1'b0);
        check_scan4("runC", 3);

        // Run D: reset during R2 of column 2, then a clean scan
        clear_logs();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        r2 = 0;
        for (int i = 0; i < 100 && r2 < 3; i++) begin
            if (state4 == S_R2) r2++;
            if (r2 < 3) tick();
        end
        check("runD_reach_r2", 32'(r2), 3);
        rst4 = 1'b1;
        #1;
        check("abort_busy", 32'(busy4), 0);
        check("abort_rd_en", 32'(rd_en4), 0);
        check("abort_addr", 32'(addr4), 0);
        check("abort_pix", 32'({p1_4, p2_4, p3_4}), 0);
        check("abort_wr_en", 32'(wr_en4), 0);
        check("abort_win_pos", 32'({win_row4, win_col4}), 0);
        check("abort_state", 32'(state4), 32'(S_IDLE));
        @(negedge clk);
        rst4 = 1'b0;
        repeat (20) tick();
        check("abort_no_done", 32'(done_cyc_q.size()), 0);
        clear_logs();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done4("runD", 200, 1'b0);
        check_scan4("runD", 0);

        // 8x8 scan with random win_ready
        for (int t = 0; t < 6; t++) begin
            for (int c = 0; c < 8; c++) begin
                exp8_q.push_back({8'(t * 8 + c), 8'(t * 8 + c + 8), 8'(t * 8 + c + 16)});
            end
        end
        mon8  = 1'b1;
        rand8 = 1'b1;
        tick();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            tick();
            if (done8) seen = 1'b1;
        end
        check("run8_done_seen", 32'(seen), 1);
        repeat (3) tick();
        rand8 = 1'b0;
        check("run8_npush", 32'(k8), 48);
        check("run8_nvalid", 32'(nval8), 36);
        covered = 0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 2; c < 8; c++) begin
                if (seen8[r][c]) covered++;
            end
        end
        check("run8_coverage", 32'(covered), 36);
        check("run8_busy_end", 32'(busy8), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
